fetch_stage: RTL and testbench

- Instruction-fetch stage. Produces the `instruction` / `immediate` pair that decodeStage consumes.
- Drives the instruction-memory address from its own PC. Assembles two-word instructions: opcode word plus 16-bit immediate word.
- Presents results to decode through a registered pipeline register with a valid bit.
- Handles hazard stalls and branch/jump redirects coming back from later stages.

---
 rtl/fetch_stage.sv | 124 ++++++++++++
 tb/tb_fetch_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: drives the instruction-memory address from its PC, assembles
// one- or two-word instructions and presents them to decode through a registered output stage.
module fetch_stage #(
  parameter int                 ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter logic [15:0]        NOP_WORD = 16'h0000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic [ADDR_W-1:0] im_addr_o,
  input  logic [15:0]       im_data_i,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic [15:0]       instruction_o,
  output logic [15:0]       immediate_o,
  output logic              if_valid_o,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [ADDR_W-1:0] if_next_pc_o
);

  // state     | meaning
  // FETCH     | fetching an opcode word
  // FETCH_IMM | opcode word buffered, fetching its immediate word
  typedef enum logic {FETCH, FETCH_IMM} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       op_q, op_d;
  logic [ADDR_W-1:0] op_pc_q, op_pc_d;
  logic [15:0]       instr_q, instr_d;
  logic [15:0]       imm_q, imm_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic [ADDR_W-1:0] next_pc_q, next_pc_d;

  logic [ADDR_W-1:0] pc_inc;
  logic              two_word;

  assign pc_inc   = pc_q + ADDR_W'(1);
  assign two_word = (im_data_i[15:14] == 2'b10);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    op_d      = op_q;
    op_pc_d   = op_pc_q;
    instr_d   = instr_q;
    imm_d     = imm_q;
    valid_d   = valid_q;
    if_pc_d   = if_pc_q;
    next_pc_d = next_pc_q;

    if (redirect_i) begin
      // redirect overrides a stall and drops any half-assembled instruction
      pc_d    = redirect_pc_i;
      state_d = FETCH;
      instr_d = NOP_WORD;
      imm_d   = 16'h0000;
      valid_d = 1'b0;
    end else if (!stall_i) begin
      pc_d = pc_inc;
      unique case (state_q)
        FETCH: begin
          if (two_word) begin
            op_d    = im_data_i;
            op_pc_d = pc_q;
            state_d = FETCH_IMM;
            instr_d = NOP_WORD;
            imm_d   = 16'h0000;
            valid_d = 1'b0;
          end else begin
            instr_d   = im_data_i;
            imm_d     = 16'h0000;
            valid_d   = 1'b1;
            if_pc_d   = pc_q;
            next_pc_d = pc_inc;
          end
        end
        FETCH_IMM: begin
          state_d   = FETCH;
          instr_d   = op_q;
          imm_d     = im_data_i;
          valid_d   = 1'b1;
          if_pc_d   = op_pc_q;
          next_pc_d = pc_inc;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      op_q      <= 16'h0000;
      op_pc_q   <= '0;
      instr_q   <= NOP_WORD;
      imm_q     <= 16'h0000;
      valid_q   <= 1'b0;
      if_pc_q   <= '0;
      next_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      op_q      <= op_d;
      op_pc_q   <= op_pc_d;
      instr_q   <= instr_d;
      imm_q     <= imm_d;
      valid_q   <= valid_d;
      if_pc_q   <= if_pc_d;
      next_pc_q <= next_pc_d;
    end
  end

  assign im_addr_o     = pc_q;
  assign instruction_o = instr_q;
  assign immediate_o   = imm_q;
  assign if_valid_o    = valid_q;
  assign if_pc_o       = if_pc_q;
  assign if_next_pc_o  = next_pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand-written corner sequences and a
// randomized run against a word-assembly reference model.
module tb_fetch_stage;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [15:0] im_addr_o, im_data_i;
  logic        stall_i = 1'b0, redirect_i = 1'b0;
  logic [15:0] redirect_pc_i = 16'h0000;
  logic [15:0] instruction_o, immediate_o, if_pc_o, if_next_pc_o;
  logic        if_valid_o;

  logic [15:0] mem [65536];
  assign im_data_i = mem[im_addr_o];

  int tests = 0;
  int fails = 0;

  fetch_stage dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .im_addr_o(im_addr_o), .im_data_i(im_data_i),
    .stall_i(stall_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .instruction_o(instruction_o), .immediate_o(immediate_o), .if_valid_o(if_valid_o),
    .if_pc_o(if_pc_o), .if_next_pc_o(if_next_pc_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // full output check; if_pc/if_next_pc are only meaningful with a valid instruction
  task automatic chk_out(input string tag, input logic v, input logic [15:0] ins,
                         input logic [15:0] imm, input logic [15:0] pc,
                         input logic [15:0] npc, input logic [15:0] addr);
    chk({tag, ".valid"}, 32'(if_valid_o), 32'(v));
    chk({tag, ".instr"}, 32'(instruction_o), 32'(ins));
    chk({tag, ".imm"},   32'(immediate_o), 32'(imm));
    chk({tag, ".addr"},  32'(im_addr_o), 32'(addr));
    if (v) begin
      chk({tag, ".if_pc"},   32'(if_pc_o), 32'(pc));
      chk({tag, ".next_pc"}, 32'(if_next_pc_o), 32'(npc));
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 16'h0000;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  typedef struct {
    logic        stall;
    logic        redir;
    logic [15:0] rpc;
    logic        v;
    logic [15:0] ins, imm, pc, npc, addr;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic r, input logic [15:0] rpc,
                              input logic v, input logic [15:0] ins, input logic [15:0] imm,
                              input logic [15:0] pc, input logic [15:0] npc,
                              input logic [15:0] addr);
    vec_t t;
    t.stall = s; t.redir = r; t.rpc = rpc; t.v = v;
    t.ins = ins; t.imm = imm; t.pc = pc; t.npc = npc; t.addr = addr;
    return t;
  endfunction

  // reference model: words are collected in fetch order and an instruction is emitted
  // once the collected words form a complete single- or two-word instruction
  typedef struct { logic [15:0] a; logic [15:0] w; } word_t;
  word_t       asmq[$];
  logic [15:0] m_pc;
  logic        e_v;
  logic [15:0] e_ins, e_imm, e_pc, e_npc;

  function automatic bit is_two(input logic [15:0] w);
    return w[15:11] inside {[5'b10000:5'b10111]};
  endfunction

  task automatic model_reset();
    asmq.delete();
    m_pc = 16'h0000;
    e_v = 1'b0; e_ins = 16'h0000; e_imm = 16'h0000; e_pc = 16'h0000; e_npc = 16'h0000;
  endtask

  task automatic model_edge(input logic s, input logic r, input logic [15:0] rpc);
    word_t cur;
    if (r) begin
      asmq.delete();
      m_pc = rpc;
      e_v = 1'b0; e_ins = 16'h0000; e_imm = 16'h0000;
    end else if (!s) begin
      cur.a = m_pc; cur.w = mem[m_pc];
      asmq.push_back(cur);
      m_pc = m_pc + 16'd1;
      if (asmq.size() == 1 && !is_two(asmq[0].w)) begin
        e_v = 1'b1; e_ins = asmq[0].w; e_imm = 16'h0000; e_pc = asmq[0].a; e_npc = m_pc;
        asmq.delete();
      end else if (asmq.size() == 2) begin
        e_v = 1'b1; e_ins = asmq[0].w; e_imm = asmq[1].w; e_pc = asmq[0].a; e_npc = m_pc;
        asmq.delete();
      end else begin
        e_v = 1'b0; e_ins = 16'h0000; e_imm = 16'h0000;
      end
    end
  endtask

  vec_t tbl[18];

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[0] = 16'h1802; mem[1] = 16'h0805; mem[2] = 16'h1000;
    mem[3] = 16'h2001; mem[4] = 16'h2002; mem[5] = 16'h2003;
    mem[6] = 16'hA100; mem[7] = 16'h1234; mem[8] = 16'h2004;
    mem[9] = 16'hA200; mem[10] = 16'h5555;
    mem[16'h40] = 16'h3040; mem[16'h41] = 16'h3041;
    mem[16'h10] = 16'h3010; mem[16'h11] = 16'h3011;

    tbl[0]  = mk(0, 0, 16'h0000, 1, 16'h1802, 0, 16'h0000, 16'h0001, 16'h0001);
    tbl[1]  = mk(0, 0, 16'h0000, 1, 16'h0805, 0, 16'h0001, 16'h0002, 16'h0002);
    tbl[2]  = mk(0, 0, 16'h0000, 1, 16'h1000, 0, 16'h0002, 16'h0003, 16'h0003);
    tbl[3]  = mk(0, 0, 16'h0000, 1, 16'h2001, 0, 16'h0003, 16'h0004, 16'h0004);
    tbl[4]  = mk(0, 0, 16'h0000, 1, 16'h2002, 0, 16'h0004, 16'h0005, 16'h0005);
    tbl[5]  = mk(1, 0, 16'h0000, 1, 16'h2002, 0, 16'h0004, 16'h0005, 16'h0005);
    tbl[6]  = mk(1, 0, 16'h0000, 1, 16'h2002, 0, 16'h0004, 16'h0005, 16'h0005);
    tbl[7]  = mk(1, 0, 16'h0000, 1, 16'h2002, 0, 16'h0004, 16'h0005, 16'h0005);
    tbl[8]  = mk(0, 0, 16'h0000, 1, 16'h2003, 0, 16'h0005, 16'h0006, 16'h0006);
    tbl[9]  = mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0007);
    tbl[10] = mk(0, 0, 16'h0000, 1, 16'hA100, 16'h1234, 16'h0006, 16'h0008, 16'h0008);
    tbl[11] = mk(0, 0, 16'h0000, 1, 16'h2004, 0, 16'h0008, 16'h0009, 16'h0009);
    tbl[12] = mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h000A);
    tbl[13] = mk(0, 1, 16'h0040, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0040);
    tbl[14] = mk(0, 0, 16'h0000, 1, 16'h3040, 0, 16'h0040, 16'h0041, 16'h0041);
    tbl[15] = mk(1, 1, 16'h0010, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0010);
    tbl[16] = mk(0, 0, 16'h0000, 1, 16'h3010, 0, 16'h0010, 16'h0011, 16'h0011);
    tbl[17] = mk(1, 0, 16'h0000, 1, 16'h3010, 0, 16'h0010, 16'h0011, 16'h0011);

    // reset values
    #12;
    chk_out("reset", 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    chk("reset.if_pc", 32'(if_pc_o), 32'h0);
    chk("reset.next_pc", 32'(if_next_pc_o), 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < 18; i++) begin
      stall_i = tbl[i].stall; redirect_i = tbl[i].redir; redirect_pc_i = tbl[i].rpc;
      step();
      chk_out($sformatf("vec%0d", i), tbl[i].v, tbl[i].ins, tbl[i].imm,
              tbl[i].pc, tbl[i].npc, tbl[i].addr);
    end
    stall_i = 1'b0; redirect_i = 1'b0;

    // two-word instruction at address 0
    mem[0] = 16'hA100; mem[1] = 16'h1234; mem[2] = 16'h2222;
    redirect_i = 1'b1; redirect_pc_i = 16'h0000;
    step();
    redirect_i = 1'b0;
    chk_out("tw.redir", 1'b0, 16'h0000, 16'h0000, 16'h0, 16'h0, 16'h0000);
    step();
    chk_out("tw.bubble", 1'b0, 16'h0000, 16'h0000, 16'h0, 16'h0, 16'h0001);
    step();
    chk_out("tw.present", 1'b1, 16'hA100, 16'h1234, 16'h0000, 16'h0002, 16'h0002);
    step();
    chk_out("tw.next", 1'b1, 16'h2222, 16'h0000, 16'h0002, 16'h0003, 16'h0003);

    // two-word opcode at the last address takes its immediate from address 0
    mem[16'hFFFF] = 16'hA123; mem[0] = 16'hBEEF; mem[1] = 16'h1111;
    redirect_i = 1'b1; redirect_pc_i = 16'hFFFF;
    step();
    redirect_i = 1'b0;
    chk_out("wrap.redir", 1'b0, 16'h0000, 16'h0000, 16'h0, 16'h0, 16'hFFFF);
    step();
    chk_out("wrap.bubble", 1'b0, 16'h0000, 16'h0000, 16'h0, 16'h0, 16'h0000);
    step();
    chk_out("wrap.present", 1'b1, 16'hA123, 16'hBEEF, 16'hFFFF, 16'h0001, 16'h0001);

    // asynchronous reset in the middle of a two-word fetch
    redirect_i = 1'b1; redirect_pc_i = 16'hFFFF;
    step();
    redirect_i = 1'b0;
    step();
    chk_out("arst.pre", 1'b0, 16'h0000, 16'h0000, 16'h0, 16'h0, 16'h0000);
    step();
    chk_out("arst.valid_pre", 1'b1, 16'hA123, 16'hBEEF, 16'hFFFF, 16'h0001, 16'h0001);
    redirect_i = 1'b1; redirect_pc_i = 16'h0100;
    mem[16'h0100] = 16'hA555; mem[16'h0101] = 16'h7777;
    step();
    redirect_i = 1'b0;
    step();
    chk_out("arst.half", 1'b0, 16'h0000, 16'h0000, 16'h0, 16'h0, 16'h0101);
    #2 rst_ni = 1'b0;
    #1;
    chk_out("arst.now", 1'b0, 16'h0000, 16'h0000, 16'h0, 16'h0, 16'h0000);
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();
    chk_out("arst.after1", 1'b0, 16'h0000, 16'h0000, 16'h0, 16'h0, 16'h0001);
    step();
    chk_out("arst.after2", 1'b1, 16'hBEEF, 16'h1111, 16'h0000, 16'h0002, 16'h0002);

    // randomized run against the reference model
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic s, r;
      logic [15:0] rpc;
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 9) == 0);
      rpc = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(16'hFFF8, 16'hFFFF))
                                        : 16'($urandom);
      stall_i = s; redirect_i = r; redirect_pc_i = rpc;
      model_edge(s, r, rpc);
      step();
      chk_out($sformatf("rnd%0d", c), e_v, e_ins, e_imm, e_pc, e_npc, m_pc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
